mdu_iter: RTL

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit.
- Successor to the single-cycle combinational MUL/DIV paths in the execute-stage ALU.
- Sits beside the ALU in EX and stalls the pipeline through a valid/ready handshake.
- Supports a pipeline flush, RISC-V-exact divide-by-zero and overflow results, and a configurable multiplier latency.

---
 rtl/mdu_pkg.sv | 12 +
 rtl/mdu_iter_if.sv | 15 +
 rtl/mdu_iter_div_core.sv | 61 ++++++
 rtl/mdu_iter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: funct3 opcodes and FSM state encodings shared by the multiply/divide unit
package mdu_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response handshake bundle between the pipeline and the multiply/divide unit
interface mdu_iter_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] r;
  logic            busy;
  modport master (output in_valid, op, a, b, flush, out_ready, input in_ready, out_valid, r, busy);
  modport slave (input in_valid, op, a, b, flush, out_ready, output in_ready, out_valid, r, busy);
endinterface

// File: rtl/mdu_iter_div_core.sv
// div_core: iterative unsigned restoring divider, one quotient bit per cycle
module div_core #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            done
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [XLEN:0]    t, diff;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign done = run_q && cnt_q == '0;
  // shift the next dividend bit into the partial remainder and subtract the divisor if it fits
  always_comb begin
    t     = {rem_q, quo_q[XLEN-1]};
    diff  = t - {1'b0, dvs_q};
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (kill) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CNT_W'(XLEN);
      run_d = 1'b1;
    end else if (cnt_q != '0) begin
      rem_d = diff[XLEN] ? t[XLEN-1:0] : diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
      cnt_d = cnt_q - 1'b1;
    end
  end
  // divider state registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake and flush
module mdu_iter import mdu_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input logic       clk,
  input logic       clrn,
  mdu_iter_if.slave io
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [XLEN-1:0]             r_q, r_d, sr_q, sr_d;
  logic                        spec_q, spec_d, isrem_q, isrem_d, neg_q, neg_d;
  logic [MUL_LAT-1:0][XLEN-1:0] pipe_q, pipe_d;
  logic                        accept, sdiv, an, bn, dz, ovf, dv_start, dv_done;
  logic [XLEN-1:0]             ma, mb, sres, psel, res, dv_quo, dv_rem;
  logic [2*XLEN-1:0]           ae, be, prod;
  assign io.in_ready  = state_q == S_IDLE && !io.flush;
  assign io.out_valid = state_q == S_DONE;
  assign io.busy      = state_q != S_IDLE;
  assign io.r         = r_q;
  assign accept       = io.in_valid && io.in_ready;
  // operand decode: divide magnitudes, special-case results and the selected product word
  always_comb begin
    sdiv = !io.op[0];
    an   = sdiv && io.a[XLEN-1];
    bn   = sdiv && io.b[XLEN-1];
    ma   = an ? -io.a : io.a;
    mb   = bn ? -io.b : io.b;
    dz   = io.b == '0;
    ovf  = sdiv && io.a == SMIN && io.b == '1;
    sres = dz ? (io.op[1] ? io.a : '1) : (io.op[1] ? '0 : io.a);
    ae   = {{XLEN{io.op != OP_MULHU && io.a[XLEN-1]}}, io.a};
    be   = {{XLEN{io.op == OP_MULH && io.b[XLEN-1]}}, io.b};
    prod = ae * be;
    psel = io.op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    res  = isrem_q ? dv_rem : dv_quo;
  end
  div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .clrn     (clrn),
    .start    (dv_start),
    .kill     (io.flush),
    .dividend (ma),
    .divisor  (mb),
    .quo      (dv_quo),
    .rem      (dv_rem),
    .done     (dv_done)
  );
  // next-state logic; flush overrides every transition and freezes r
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    sr_d     = sr_q;
    spec_d   = spec_q;
    isrem_d  = isrem_q;
    neg_d    = neg_q;
    dv_start = 1'b0;
    pipe_d[0] = accept ? psel : pipe_q[0];
    for (int i = 1; i < MUL_LAT; i++) pipe_d[i] = pipe_q[i-1];
    case (state_q)
      S_IDLE: if (accept) begin
        isrem_d = io.op[1];
        neg_d   = io.op[1] ? an : an ^ bn;
        spec_d  = dz || ovf;
        sr_d    = sres;
        if (!io.op[2]) begin
          state_d = S_MUL;
          cnt_d   = CNT_W'(MUL_LAT - 1);
        end else if (dz || ovf) begin
          state_d = S_FIX;
        end else begin
          state_d  = S_DIV;
          cnt_d    = CNT_W'(XLEN);
          dv_start = 1'b1;
        end
      end
      S_MUL: begin
        state_d = cnt_q == '0 ? S_DONE : S_MUL;
        r_d     = cnt_q == '0 ? pipe_q[MUL_LAT-1] : r_q;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      S_DIV: begin
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = dv_done ? S_FIX : S_DIV;
      end
      S_FIX: begin
        state_d = S_DONE;
        r_d     = spec_q ? sr_q : (neg_q ? -res : res);
      end
      S_DONE:  state_d = io.out_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (io.flush) begin
      state_d = S_IDLE;
      r_d     = r_q;
    end
  end
  // state, result and operand registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      sr_q    <= '0;
      spec_q  <= 1'b0;
      isrem_q <= 1'b0;
      neg_q   <= 1'b0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      sr_q    <= sr_d;
      spec_q  <= spec_d;
      isrem_q <= isrem_d;
      neg_q   <= neg_d;
      pipe_q  <= pipe_d;
    end
  end
endmodule
